// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
// Framed command sequencer between the UART byte receiver/transmitter and the
// 93LC46 SPI engine. Accepts 5-byte frames (0x55, OP, ADDR, DATA, CHK), issues
// one SPI write/read strobe per valid frame, waits for completion with a
// timeout, and always answers with a 2-byte status/data response.
//
// Ports
//   clk50M       in   system clock
//   rst_i        in   synchronous reset, active-high
//   rx_data      in   [7:0] received byte, valid with rx_done
//   rx_done      in   1-cycle pulse, byte received
//   spi_wr       out  1-cycle write strobe
//   spi_rd       out  1-cycle read strobe
//   spi_addr     out  [7:0] SPI address, held until the next strobe
//   spi_data     out  [7:0] SPI write data, held until the next strobe
//   spi_done     in   1-cycle pulse, SPI op finished
//   spi_rd_data  in   [7:0] SPI read data, valid with spi_done
//   tx_data      out  [7:0] byte to UART transmitter, held between sends
//   tx_send      out  1-cycle send request
//   tx_done      in   1-cycle pulse, UART byte sent
//   busy         out  high whenever the sequencer is not idle
//   frame_drop   out  1-cycle pulse: gap timeout or byte ignored while busy
module spi_cmd_sequencer #(
  parameter int unsigned SPI_TIMEOUT = 1_000_000,
  parameter int unsigned GAP_TIMEOUT = 500_000
) (
  input  logic       clk50M,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       spi_wr,
  output logic       spi_rd,
  output logic [7:0] spi_addr,
  output logic [7:0] spi_data,
  input  logic       spi_done,
  input  logic [7:0] spi_rd_data,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_done,
  output logic       busy,
  output logic       frame_drop
);

  localparam int unsigned SPI_CW = $clog2(SPI_TIMEOUT + 1);
  localparam int unsigned GAP_CW = $clog2(GAP_TIMEOUT + 1);

  // Expiry fires in the last allowed cycle of the wait window.
  localparam logic [SPI_CW-1:0] SPI_LAST = SPI_CW'(SPI_TIMEOUT - 1);
  localparam logic [SPI_CW-1:0] SPI_MAX  = SPI_CW'(SPI_TIMEOUT);
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP_TIMEOUT - 1);
  localparam logic [GAP_CW-1:0] GAP_MAX  = GAP_CW'(GAP_TIMEOUT);

  localparam logic [7:0] SOF    = 8'h55;
  localparam logic [7:0] OP_WR  = 8'hA5;
  localparam logic [7:0] OP_RD  = 8'hA1;
  localparam logic [7:0] ST_OK  = 8'hAC;
  localparam logic [7:0] ST_CHK = 8'hE1;
  localparam logic [7:0] ST_OP  = 8'hE2;
  localparam logic [7:0] ST_TO  = 8'hE3;

  typedef enum logic [3:0] {
    IDLE, GET_OP, GET_ADDR, GET_DATA, GET_CHK,
    ISSUE, WAIT_SPI, TX_STAT, WAIT_TX1, TX_DATA, WAIT_TX2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d, addr_q, addr_d, data_q, data_d;
  logic [7:0]        status_q, status_d, rsp_q, rsp_d;
  logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
  logic [SPI_CW-1:0] spi_cnt_q, spi_cnt_d;

  logic       spi_wr_d, spi_rd_d, tx_send_d, busy_d, frame_drop_d;
  logic [7:0] spi_addr_d, spi_data_d, tx_data_d;

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    status_d     = status_q;
    rsp_d        = rsp_q;
    gap_cnt_d    = '0;
    spi_cnt_d    = '0;
    spi_wr_d     = 1'b0;
    spi_rd_d     = 1'b0;
    spi_addr_d   = spi_addr;
    spi_data_d   = spi_data;
    tx_data_d    = tx_data;
    tx_send_d    = 1'b0;
    busy_d       = 1'b0;
    frame_drop_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_done && rx_data == SOF) state_d = GET_OP;
      end
      GET_OP: begin
        if (rx_done) begin
          op_d    = rx_data;
          state_d = GET_ADDR;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d      = IDLE;
          frame_drop_d = 1'b1;
        end
      end
      GET_ADDR: begin
        if (rx_done) begin
          addr_d  = rx_data;
          state_d = GET_DATA;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d      = IDLE;
          frame_drop_d = 1'b1;
        end
      end
      GET_DATA: begin
        if (rx_done) begin
          data_d  = rx_data;
          state_d = GET_CHK;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d      = IDLE;
          frame_drop_d = 1'b1;
        end
      end
      GET_CHK: begin
        if (rx_done) begin
          rsp_d = 8'h00;
          // Checksum is judged before the opcode.
          if (rx_data != (op_q ^ addr_q ^ data_q)) begin
            status_d = ST_CHK;
            state_d  = TX_STAT;
          end else if (op_q == OP_WR || op_q == OP_RD) begin
            state_d = ISSUE;
          end else begin
            status_d = ST_OP;
            state_d  = TX_STAT;
          end
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d      = IDLE;
          frame_drop_d = 1'b1;
        end
      end
      ISSUE: state_d = WAIT_SPI;
      WAIT_SPI: begin
        // spi_done takes priority over a coincident timeout.
        if (spi_done) begin
          status_d = ST_OK;
          rsp_d    = (op_q == OP_RD) ? spi_rd_data : 8'h00;
          state_d  = TX_STAT;
        end else if (spi_cnt_q == SPI_LAST) begin
          status_d = ST_TO;
          rsp_d    = 8'h00;
          state_d  = TX_STAT;
        end
      end
      TX_STAT:  state_d = WAIT_TX1;
      WAIT_TX1: if (tx_done) state_d = TX_DATA;
      TX_DATA:  state_d = WAIT_TX2;
      WAIT_TX2: if (tx_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Bytes arriving outside the receive states are never queued.
    if (rx_done && !(state_q inside {IDLE, GET_OP, GET_ADDR, GET_DATA, GET_CHK}))
      frame_drop_d = 1'b1;

    // Outputs are registered so they line up with the state being entered.
    case (state_d)
      ISSUE: begin
        spi_wr_d   = (op_q == OP_WR);
        spi_rd_d   = (op_q == OP_RD);
        spi_addr_d = addr_q;
        spi_data_d = data_q;
      end
      TX_STAT: begin
        tx_send_d = 1'b1;
        tx_data_d = status_d;
      end
      TX_DATA: begin
        tx_send_d = 1'b1;
        tx_data_d = rsp_q;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);

    // Saturating counters, cleared on every state entry.
    if (state_d == state_q && state_d inside {GET_OP, GET_ADDR, GET_DATA, GET_CHK})
      gap_cnt_d = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + GAP_CW'(1);
    if (state_d == state_q && state_d == WAIT_SPI)
      spi_cnt_d = (spi_cnt_q == SPI_MAX) ? spi_cnt_q : spi_cnt_q + SPI_CW'(1);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk50M) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      status_q   <= '0;
      rsp_q      <= '0;
      gap_cnt_q  <= '0;
      spi_cnt_q  <= '0;
      spi_wr     <= 1'b0;
      spi_rd     <= 1'b0;
      spi_addr   <= '0;
      spi_data   <= '0;
      tx_data    <= '0;
      tx_send    <= 1'b0;
      busy       <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      status_q   <= status_d;
      rsp_q      <= rsp_d;
      gap_cnt_q  <= gap_cnt_d;
      spi_cnt_q  <= spi_cnt_d;
      spi_wr     <= spi_wr_d;
      spi_rd     <= spi_rd_d;
      spi_addr   <= spi_addr_d;
      spi_data   <= spi_data_d;
      tx_data    <= tx_data_d;
      tx_send    <= tx_send_d;
      busy       <= busy_d;
      frame_drop <= frame_drop_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Testbench for spi_cmd_sequencer: directed and randomized frames checked
// against a frame-level reference model of the command/response protocol.
module tb_spi_cmd_sequencer;

  localparam int unsigned SPI_TO = 40;
  localparam int unsigned GAP_TO = 30;

  logic       clk50M = 1'b0;
  logic       rst_i;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       spi_wr, spi_rd;
  logic [7:0] spi_addr, spi_data;
  logic       spi_done;
  logic [7:0] spi_rd_data;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_done;
  logic       busy, frame_drop;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] last_addr, last_data;

  always #10 clk50M = ~clk50M;

  spi_cmd_sequencer #(.SPI_TIMEOUT(SPI_TO), .GAP_TIMEOUT(GAP_TO)) dut (
    .clk50M(clk50M), .rst_i(rst_i), .rx_data(rx_data), .rx_done(rx_done),
    .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_addr(spi_addr), .spi_data(spi_data),
    .spi_done(spi_done), .spi_rd_data(spi_rd_data), .tx_data(tx_data),
    .tx_send(tx_send), .tx_done(tx_done), .busy(busy), .frame_drop(frame_drop)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    repeat (idle) tick();
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Frame-level reference: strobe kind (0 none, 1 write, 2 read), response
  // bytes, and cycles from the strobe until the status byte is sent.
  task automatic model(input logic [7:0] op, addr, data, chk, input int done_at,
                       input logic [7:0] rdd, output int strobe,
                       output logic [7:0] st, output logic [7:0] dt, output int resp_ticks);
    strobe = 0; dt = 8'h00; resp_ticks = 0;
    if (chk != (op ^ addr ^ data))            st = 8'hE1;
    else if (op != 8'hA5 && op != 8'hA1)      st = 8'hE2;
    else begin
      strobe = (op == 8'hA5) ? 1 : 2;
      if (done_at >= 1 && done_at <= int'(SPI_TO)) begin
        st = 8'hAC;
        dt = (strobe == 2) ? rdd : 8'h00;
        resp_ticks = done_at + 1;
      end else begin
        st = 8'hE3;
        resp_ticks = int'(SPI_TO) + 1;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] op, addr, data, chk, input int done_at,
                           input logic [7:0] rdd, input int rx_extra_at, input int gap_max);
    int strobe, exp_n, n;
    logic [7:0] st, dt;
    logic got;
    model(op, addr, data, chk, done_at, rdd, strobe, st, dt, exp_n);
    send_byte(8'h55, $urandom_range(0, gap_max));
    check("busy_after_sof", 8'(busy), 8'h01);
    send_byte(op,   $urandom_range(0, gap_max));
    send_byte(addr, $urandom_range(0, gap_max));
    send_byte(data, $urandom_range(0, gap_max));
    send_byte(chk,  $urandom_range(0, gap_max));
    check("spi_wr_strobe", 8'(spi_wr), 8'(strobe == 1));
    check("spi_rd_strobe", 8'(spi_rd), 8'(strobe == 2));
    if (strobe != 0) begin
      last_addr = addr;
      last_data = data;
      check("spi_addr", spi_addr, addr);
      check("spi_data", spi_data, data);
      n = 0; got = 1'b0;
      while (n < int'(SPI_TO) + 10 && !got) begin
        if (n == done_at)     begin spi_done = 1'b1; spi_rd_data = rdd; end
        if (n == rx_extra_at) begin rx_done = 1'b1; rx_data = 8'($urandom); end
        tick();
        spi_done = 1'b0;
        rx_done  = 1'b0;
        n++;
        if (n == 1) check("strobe_one_cycle", 8'(spi_wr | spi_rd), 8'h00);
        if (n - 1 == rx_extra_at) check("drop_while_busy", 8'(frame_drop), 8'h01);
        if (tx_send) got = 1'b1;
      end
      check("resp_latency", 8'(n), 8'(exp_n));
    end
    check("tx_send_status", 8'(tx_send), 8'h01);
    check("tx_status", tx_data, st);
    tick();
    check("tx_send_pulse1", 8'(tx_send), 8'h00);
    repeat ($urandom_range(0, 3)) tick();
    check("hold_wait_tx1", 8'(tx_send), 8'h00);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("tx_send_data", 8'(tx_send), 8'h01);
    check("tx_data_byte", tx_data, dt);
    tick();
    check("tx_send_pulse2", 8'(tx_send), 8'h00);
    repeat ($urandom_range(0, 3)) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("idle_busy", 8'(busy), 8'h00);
    check("addr_held", spi_addr, last_addr);
    check("data_held", spi_data, last_data);
  endtask

  initial begin
    int n;
    logic seen;
    logic [7:0] op, addr, data, chk;
    rst_i = 1'b1; rx_data = 8'h00; rx_done = 1'b0; spi_done = 1'b0;
    spi_rd_data = 8'h00; tx_done = 1'b0;
    last_addr = 8'h00; last_data = 8'h00;
    repeat (3) tick();
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_tx_send", 8'(tx_send), 8'h00);
    check("rst_spi", 8'({spi_wr, spi_rd}), 8'h00);
    check("rst_addr", spi_addr, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    rst_i = 1'b0;
    tick();

    // Non-SOF byte and stray done pulses in IDLE are ignored silently.
    send_byte(8'h12, 0);
    check("idle_junk_busy", 8'(busy), 8'h00);
    tick();
    check("idle_junk_drop", 8'(frame_drop), 8'h00);
    spi_done = 1'b1; tx_done = 1'b1; tick(); spi_done = 1'b0; tx_done = 1'b0;
    check("idle_stray_done", 8'({busy, tx_send, spi_wr}), 8'h00);

    // Write, read, bad checksum, bad opcode.
    run_frame(8'hA5, 8'h10, 8'h3C, 8'hA5 ^ 8'h10 ^ 8'h3C, 3, 8'h00, -1, 2);
    run_frame(8'hA1, 8'h20, 8'hFF, 8'hA1 ^ 8'h20 ^ 8'hFF, 5, 8'h7B, -1, 2);
    run_frame(8'hA5, 8'h10, 8'h3C, 8'h00, -1, 8'h00, -1, 2);
    run_frame(8'hB0, 8'h01, 8'h02, 8'hB3, -1, 8'h00, -1, 2);

    // SPI timeout, then spi_done coincident with the last allowed cycle.
    run_frame(8'hA5, 8'h33, 8'h44, 8'hA5 ^ 8'h33 ^ 8'h44, -1, 8'h00, -1, 1);
    run_frame(8'hA1, 8'h34, 8'h45, 8'hA1 ^ 8'h34 ^ 8'h45, int'(SPI_TO), 8'hC3, -1, 1);

    // Gap timeout after two bytes, then a frame using the longest legal gaps.
    send_byte(8'h55, 0);
    send_byte(8'hA5, 0);
    n = 0; seen = 1'b0;
    while (n < int'(GAP_TO) + 10 && !frame_drop) begin
      tick();
      n++;
      if (tx_send) seen = 1'b1;
    end
    check("gap_drop_latency", 8'(n), 8'(GAP_TO));
    check("gap_drop_pulse", 8'(frame_drop), 8'h01);
    check("gap_idle", 8'(busy), 8'h00);
    check("gap_no_tx", 8'(seen), 8'h00);
    tick();
    check("gap_drop_one_cycle", 8'(frame_drop), 8'h00);
    run_frame(8'hA5, 8'h5A, 8'h66, 8'hA5 ^ 8'h5A ^ 8'h66, 2, 8'h00, -1, int'(GAP_TO) - 1);

    // Extra byte while waiting on SPI.
    run_frame(8'hA1, 8'h07, 8'h08, 8'hA1 ^ 8'h07 ^ 8'h08, 6, 8'h9D, 2, 1);

    // Randomized frames.
    for (int i = 0; i < 24; i++) begin
      int sel, dn;
      sel  = $urandom_range(0, 3);
      op   = (sel < 2) ? 8'hA5 : (sel == 2) ? 8'hA1 : 8'($urandom);
      addr = 8'($urandom);
      data = 8'($urandom);
      chk  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (op ^ addr ^ data);
      dn   = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, SPI_TO);
      run_frame(op, addr, data, chk, dn, 8'($urandom), -1, 3);
    end

    // Reset while waiting for the first tx_done aborts with no response.
    send_byte(8'h55, 0); send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'h02, 0); send_byte(8'hA5 ^ 8'h01 ^ 8'h02, 0);
    tick(); tick();
    spi_done = 1'b1; tick(); spi_done = 1'b0;
    check("pre_rst_tx_send", 8'(tx_send), 8'h01);
    tick(); tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check("rst_mid_busy", 8'(busy), 8'h00);
    check("rst_mid_outs", 8'({spi_wr, spi_rd, tx_send, frame_drop}), 8'h00);
    check("rst_mid_tx_data", tx_data, 8'h00);
    check("rst_mid_addr", spi_addr, 8'h00);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tx_done = (k == 1 || k == 4);
      tick();
      if (tx_send) seen = 1'b1;
    end
    tx_done = 1'b0;
    check("rst_no_tx", 8'(seen), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
